// File: rtl/video_pkg.sv
// Shared definitions for the 960x540 <-> 1080p video path.
//   - Default source resolution (SRC_XRES_DEF x SRC_YRES_DEF).
//   - rgb888_t: packed R/G/B pixel.
//   - Frame-buffer word format {PIX_PAD, R, G, B} with pack/unpack helpers.
//   - State and pixel-source encodings used by the upscaler.
package video_pkg;

  localparam int SRC_XRES_DEF = 960;
  localparam int SRC_YRES_DEF = 540;

  // Pad byte occupying [31:24] of every frame-buffer word.
  localparam logic [7:0] PIX_PAD = 8'h00;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef enum logic [1:0] {
    S_WAIT_VS = 2'd0,
    S_FRAME   = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  // Where the output register takes its next pixel from.
  typedef enum logic [2:0] {
    SEL_BLACK = 3'd0,
    SEL_FIFO  = 3'd1,  // fresh FIFO word (even line, even pixel)
    SEL_UFLOW = 3'd2,  // FIFO was empty: black pair
    SEL_HOLD  = 3'd3,  // repeat of the previous FIFO pixel
    SEL_LB    = 3'd4   // replay from the line buffer (odd line)
  } pix_sel_e;

  // Payload of a frame-buffer word; the pad byte is not part of it.
  function automatic rgb888_t unpack_pixel(input logic [23:0] payload);
    return rgb888_t'(payload);
  endfunction

  function automatic logic [31:0] pack_pixel(input rgb888_t px);
    return {PIX_PAD, px};
  endfunction

endpackage

// File: rtl/line_buf_sdp.sv
// Simple dual-port line buffer: 2**AW x DW, one write port, one read port,
// registered read data (1-cycle latency). No reset on the array or read
// register so that it maps onto block RAM.
//   clk    : clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address (sampled every cycle)
//   rdata  : read data, valid one cycle after raddr
module line_buf_sdp #(
  parameter int AW = 10,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/video_upscale_960_540.sv
// 2x nearest-neighbour upscaler: SRC_XRES x SRC_YRES RGB888 words from a
// non-show-ahead read FIFO become 2*SRC_XRES x 2*SRC_YRES video aligned to
// an external output timing generator.
// Even output lines pull one FIFO word per pixel pair and store it in the
// line buffer; odd output lines replay the line buffer with no FIFO reads.
// Ports:
//   pixclk_in, rst_n          : clock, synchronous active-low reset
//   vs_in, hs_in, de_in       : output timing
//   rd_req/rd_data/rd_empty   : FIFO read side (data valid 1 cycle after rd_req)
//   rd_frame_start            : 1-cycle pulse after a vs_in rising edge
//   vs_out, hs_out, de_out    : timing delayed 2 cycles
//   r_out, g_out, b_out       : output pixel, aligned with de_out
//   underflow                 : sticky FIFO-empty flag, cleared on frame start
module video_upscale_960_540
  import video_pkg::*;
#(
  parameter int SRC_XRES = SRC_XRES_DEF,
  parameter int SRC_YRES = SRC_YRES_DEF,
  parameter int LB_AW    = 10
) (
  input  logic        pixclk_in,
  input  logic        rst_n,
  input  logic        vs_in,
  input  logic        hs_in,
  input  logic        de_in,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  input  logic        rd_empty,
  output logic        rd_frame_start,
  output logic        vs_out,
  output logic        hs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        underflow
);

  localparam logic [11:0] OUT_W = 12'(2 * SRC_XRES);
  localparam logic [11:0] OUT_H = 12'(2 * SRC_YRES);

  state_e           state_q, state_d;
  logic [11:0]      out_x_q, out_x_d;
  logic [11:0]      out_y_q, out_y_d;
  logic             vs_prev_q, de_prev_q;
  pix_sel_e         sel_q, sel_d;
  logic [LB_AW-1:0] lb_waddr_q, lb_waddr_d;
  logic             vs_s1_q, hs_s1_q, de_s1_q;
  logic             vs_out_q, hs_out_q, de_out_q;
  rgb888_t          pix_q, pix_d;
  rgb888_t          hold_q, hold_d;
  logic             underflow_q, underflow_d;
  logic             frame_start_q;

  logic             vs_rise, de_fall;
  logic             act, pair_slot;
  logic             lb_we;
  rgb888_t          lb_wdata;
  logic [23:0]      lb_rdata;
  logic [LB_AW-1:0] lb_raddr;
  logic             unused_pad;

  assign unused_pad = ^rd_data[31:24];

  assign vs_rise = vs_in & ~vs_prev_q;
  assign de_fall = ~de_in & de_prev_q;

  // A pixel slot inside the visible source area of a running frame.
  assign act = (state_q == S_FRAME) && (out_y_q < OUT_H) && !vs_in &&
               de_in && (out_x_q < OUT_W);
  // First pixel of a pair on an even line: the only place a word is fetched.
  assign pair_slot = act && !out_y_q[0] && !out_x_q[0];

  // Gated with rst_n so no strobe escapes during the reset cycle itself.
  assign rd_req = rst_n && pair_slot && !rd_empty;

  assign lb_raddr   = out_x_q[LB_AW:1];
  assign lb_waddr_d = out_x_q[LB_AW:1];

  always_comb begin
    out_x_d = out_x_q;
    out_y_d = out_y_q;
    if (vs_in) begin
      out_x_d = '0;
      out_y_d = '0;
    end else if (de_in) begin
      out_x_d = out_x_q + 12'd1;
    end else if (de_fall) begin
      out_x_d = '0;
      if (out_y_q < OUT_H) begin
        out_y_d = out_y_q + 12'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FRAME: if (out_y_q >= OUT_H) state_d = S_DONE;
      default: ;
    endcase
    if (vs_rise) begin
      state_d = S_FRAME;
    end
  end

  // Stage 1: decide the pixel source for the slot presented this cycle.
  always_comb begin
    sel_d = SEL_BLACK;
    if (act) begin
      if (out_y_q[0]) begin
        sel_d = SEL_LB;
      end else if (out_x_q[0]) begin
        sel_d = SEL_HOLD;
      end else if (rd_empty) begin
        sel_d = SEL_UFLOW;
      end else begin
        sel_d = SEL_FIFO;
      end
    end
  end

  // Stage 2: FIFO data / line-buffer data arrive now; load the output.
  // On underflow black is stored in both the hold register and the line
  // buffer so the whole 2x2 block of that source pixel stays black.
  always_comb begin
    pix_d    = '0;
    hold_d   = hold_q;
    lb_we    = 1'b0;
    lb_wdata = unpack_pixel(rd_data[23:0]);
    case (sel_q)
      SEL_FIFO: begin
        pix_d  = unpack_pixel(rd_data[23:0]);
        hold_d = unpack_pixel(rd_data[23:0]);
        lb_we  = 1'b1;
      end
      SEL_UFLOW: begin
        hold_d   = '0;
        lb_we    = 1'b1;
        lb_wdata = '0;
      end
      SEL_HOLD: pix_d = hold_q;
      SEL_LB:   pix_d = rgb888_t'(lb_rdata);
      default:  ;
    endcase
  end

  always_comb begin
    underflow_d = underflow_q;
    if (pair_slot && rd_empty) begin
      underflow_d = 1'b1;
    end
    if (vs_rise) begin
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge pixclk_in) begin
    if (!rst_n) begin
      state_q       <= S_WAIT_VS;
      out_x_q       <= '0;
      out_y_q       <= '0;
      vs_prev_q     <= 1'b0;
      de_prev_q     <= 1'b0;
      sel_q         <= SEL_BLACK;
      lb_waddr_q    <= '0;
      vs_s1_q       <= 1'b0;
      hs_s1_q       <= 1'b0;
      de_s1_q       <= 1'b0;
      vs_out_q      <= 1'b0;
      hs_out_q      <= 1'b0;
      de_out_q      <= 1'b0;
      pix_q         <= '0;
      hold_q        <= '0;
      underflow_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      out_x_q       <= out_x_d;
      out_y_q       <= out_y_d;
      vs_prev_q     <= vs_in;
      de_prev_q     <= de_in;
      sel_q         <= sel_d;
      lb_waddr_q    <= lb_waddr_d;
      vs_s1_q       <= vs_in;
      hs_s1_q       <= hs_in;
      de_s1_q       <= de_in;
      vs_out_q      <= vs_s1_q;
      hs_out_q      <= hs_s1_q;
      de_out_q      <= de_s1_q;
      pix_q         <= pix_d;
      hold_q        <= hold_d;
      underflow_q   <= underflow_d;
      frame_start_q <= vs_rise;
    end
  end

  line_buf_sdp #(
    .AW (LB_AW),
    .DW (24)
  ) u_line_buf (
    .clk   (pixclk_in),
    .we    (lb_we),
    .waddr (lb_waddr_q),
    .wdata (lb_wdata),
    .raddr (lb_raddr),
    .rdata (lb_rdata)
  );

  assign rd_frame_start = frame_start_q;
  assign vs_out         = vs_out_q;
  assign hs_out         = hs_out_q;
  assign de_out         = de_out_q;
  assign r_out          = pix_q.r;
  assign g_out          = pix_q.g;
  assign b_out          = pix_q.b;
  assign underflow      = underflow_q;

endmodule

// File: tb/tb_video_upscale_960_540.sv
// Bench for video_upscale_960_540 at a reduced 8x6 source resolution.
// A FIFO emulator feeds random frames; a reference model built from
// source-image arrays predicts every output cycle.
module tb_video_upscale_960_540;
  import video_pkg::*;

  localparam int SX = 8;
  localparam int SY = 6;
  localparam int AW = 3;
  localparam int OW = 2 * SX;
  localparam int OH = 2 * SY;

  logic        pixclk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
  logic        rd_empty = 1'b1;
  logic [31:0] rd_data = '0;
  logic        rd_req, rd_frame_start, vs_out, hs_out, de_out, underflow;
  logic [7:0]  r_out, g_out, b_out;

  always #5 pixclk_in = ~pixclk_in;

  video_upscale_960_540 #(
    .SRC_XRES (SX),
    .SRC_YRES (SY),
    .LB_AW    (AW)
  ) dut (
    .pixclk_in      (pixclk_in),
    .rst_n          (rst_n),
    .vs_in          (vs_in),
    .hs_in          (hs_in),
    .de_in          (de_in),
    .rd_req         (rd_req),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .rd_frame_start (rd_frame_start),
    .vs_out         (vs_out),
    .hs_out         (hs_out),
    .de_out         (de_out),
    .r_out          (r_out),
    .g_out          (g_out),
    .b_out          (b_out),
    .underflow      (underflow)
  );

  typedef struct packed {
    logic        vs;
    logic        hs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] preload [SX*SY];
  logic [31:0] fifo [$];
  logic [23:0] lb_model [SX];
  int          m_rd_idx = 0, m_x = 0, m_y = 0, frame_rd_cnt = 0;
  bit          m_valid = 0, prev_vs = 0, prev_de = 0, fs_reg = 0, uf_reg = 0;
  exp_t        p1 = '0, p2 = '0;
  bit          have_pending = 0;
  logic [31:0] pending = '0;

  task automatic new_image();
    for (int k = 0; k < SX*SY; k++) preload[k] = $urandom;
  endtask

  // One clock cycle: drive inputs, predict, then check at the falling edge.
  task automatic cycle(input bit vs, input bit hs, input bit de, input bit fe, input bit rst);
    exp_t e;
    bit   exp_rd, vs_rise, uf_ev;
    logic [23:0] px;
    @(posedge pixclk_in); #1;
    rst_n = !rst; vs_in = vs; hs_in = hs; de_in = de;
    rd_empty = fe || (fifo.size() == 0);
    rd_data = have_pending ? pending : $urandom;
    have_pending = 0;

    vs_rise = vs && !prev_vs;
    exp_rd = 0; uf_ev = 0; px = '0;
    if (!rst && m_valid && !vs && de && m_x < OW && m_y < OH) begin
      if (m_y % 2 == 0 && m_x % 2 == 0) begin
        if (rd_empty) begin
          uf_ev = 1;
          lb_model[m_x/2] = '0;
        end else begin
          exp_rd = 1;
          lb_model[m_x/2] = preload[m_rd_idx][23:0];
          m_rd_idx++;
        end
      end
      px = lb_model[m_x/2];
    end
    e = '{vs: vs, hs: hs, de: de, rgb: px};

    if (rst) begin
      m_x = 0; m_y = 0; m_valid = 0; prev_vs = 0; prev_de = 0;
    end else begin
      if (vs) begin
        m_x = 0; m_y = 0;
      end else if (de) begin
        m_x++;
      end else if (prev_de) begin
        m_x = 0;
        if (m_y < OH) m_y++;
      end
      if (vs_rise) begin
        m_valid = 1; m_rd_idx = 0;
      end
      prev_vs = vs; prev_de = de;
    end

    @(negedge pixclk_in);
    checks++;
    if (rd_req !== exp_rd) begin
      errors++;
      $display("FAIL rd_req t=%0t got %b exp %b", $time, rd_req, exp_rd);
    end
    if (rd_req === 1'b1) begin
      if (fifo.size() > 0) pending = fifo.pop_front();
      have_pending = 1;
      frame_rd_cnt++;
    end
    checks++;
    if ({vs_out, hs_out, de_out} !== {p2.vs, p2.hs, p2.de}) begin
      errors++;
      $display("FAIL timing t=%0t got vs/hs/de %b%b%b exp %b%b%b", $time,
               vs_out, hs_out, de_out, p2.vs, p2.hs, p2.de);
    end
    checks++;
    if ({r_out, g_out, b_out} !== p2.rgb) begin
      errors++;
      $display("FAIL pixel t=%0t got %06h exp %06h", $time, {r_out, g_out, b_out}, p2.rgb);
    end
    checks++;
    if (rd_frame_start !== fs_reg) begin
      errors++;
      $display("FAIL frame_start t=%0t got %b exp %b", $time, rd_frame_start, fs_reg);
    end
    checks++;
    if (underflow !== uf_reg) begin
      errors++;
      $display("FAIL underflow t=%0t got %b exp %b", $time, underflow, uf_reg);
    end
    // DDR reader restarts the frame on rd_frame_start.
    if (rd_frame_start === 1'b1) begin
      fifo = {};
      for (int k = 0; k < SX*SY; k++) fifo.push_back(preload[k]);
      frame_rd_cnt = 0;
    end

    p2 = p1; p1 = e;
    if (rst) begin
      p1 = '0; p2 = '0;
      fs_reg = 0; uf_reg = 0;
    end else begin
      fs_reg = vs_rise;
      uf_reg = vs_rise ? 1'b0 : (uf_reg | uf_ev);
    end
  endtask

  task automatic run_frame(input int lines, input int des, input int uf_line, input int uf_col,
                           input int rst_line, input int stop_line, input bit with_vs);
    if (with_vs) repeat (3) cycle(1, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);
    for (int l = 0; l < lines; l++) begin
      repeat (2) cycle(0, 1, 0, 0, 0);
      repeat (2) cycle(0, 0, 0, 0, 0);
      for (int c = 0; c < des; c++)
        cycle(0, 0, 1, (l == uf_line && c == uf_col), (l == rst_line && c >= 3 && c < 6));
      repeat (2) cycle(0, 0, 0, 0, 0);
      if (l == stop_line) break;
    end
    repeat (4) cycle(0, 0, 0, 0, 0);
  endtask

  task automatic check_reads(input string name, input int exp_cnt);
    checks++;
    if (frame_rd_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s read count got %0d exp %0d", name, frame_rd_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (4) cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), 0, 1);
    // Timing without a vsync: design must stay idle.
    run_frame(OH, OW, -1, -1, -1, -1, 0);
    check_reads("no_vsync", 0);
    $display("test_reset done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_full_frame();
    new_image();
    run_frame(OH, OW, -1, -1, -1, -1, 1);
    check_reads("full_frame", SX*SY);
    $display("test_full_frame done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_fixed_pixels();
    rgb888_t a, b;
    new_image();
    a = '{r: 8'h11, g: 8'h22, b: 8'h33};
    b = '{r: 8'h44, g: 8'h55, b: 8'h66};
    preload[0] = pack_pixel(a);
    preload[1] = pack_pixel(b);
    run_frame(OH, OW, -1, -1, -1, -1, 1);
    check_reads("fixed_pixels", SX*SY);
    $display("test_fixed_pixels done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_underflow();
    new_image();
    run_frame(OH, OW, 4, 6, -1, -1, 1);
    checks++;
    if (underflow !== 1'b1) begin
      errors++;
      $display("FAIL underflow_sticky got %b exp 1", underflow);
    end
    check_reads("underflow", SX*SY - 1);
    new_image();
    run_frame(OH, OW, -1, -1, -1, -1, 1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL underflow_cleared got %b exp 0", underflow);
    end
    check_reads("after_underflow", SX*SY);
    $display("test_underflow done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_mid_frame();
    new_image();
    run_frame(OH, OW, -1, -1, 7, -1, 1);
    new_image();
    run_frame(OH, OW, -1, -1, -1, -1, 1);
    check_reads("after_reset", SX*SY);
    $display("test_reset_mid_frame done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_excess();
    new_image();
    run_frame(OH + 2, OW + 2, -1, -1, -1, -1, 1);
    check_reads("excess", SX*SY);
    $display("test_excess done, checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_vs_restart();
    new_image();
    run_frame(OH, OW, -1, -1, -1, 9, 1);
    check_reads("aborted_frame", 5 * SX);
    new_image();
    run_frame(OH, OW, -1, -1, -1, -1, 1);
    check_reads("restarted_frame", SX*SY);
    $display("test_vs_restart done, checks=%0d errors=%0d", checks, errors);
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_fixed_pixels();
    test_underflow();
    test_reset_mid_frame();
    test_excess();
    test_vs_restart();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_upscale_960_540.md
Name: video_upscale_960_540

Overview:
- Read-side counterpart of the 1080p→960×540 downscaler: consumes 960×540 RGB888 words from the frame-buffer read FIFO and produces 1920×1080 RGB888 video by 2× nearest-neighbour replication.
- Driven by the 1080p output timing generator (vs/hs/de).
- Sits between the DDR read FIFO and the HDMI transmit path.
- Each source pixel is emitted twice horizontally. Each source line is emitted twice vertically: read from the FIFO on even output lines, replayed from an internal line buffer on odd lines.

Parameters:
- SRC_XRES, 960, source pixels per line; output width = 2*SRC_XRES.
- SRC_YRES, 540, source lines per frame; output height = 2*SRC_YRES.
- LB_AW, 10, line-buffer address width; 2**LB_AW ≥ SRC_XRES.

Ports:
- pixclk_in  in  1  pixel clock; the single clock domain of the block.
- rst_n  in  1  synchronous, active-low reset.
- vs_in  in  1  output-timing vsync, active high.
- hs_in  in  1  output-timing hsync.
- de_in  in  1  output-timing data enable.
- rd_req  out  1  FIFO read strobe (non-show-ahead; data is valid 1 cycle after the strobe).
- rd_data  in  32  FIFO word {8'b0,R,G,B}; [31:24] ignored.
- rd_empty  in  1  FIFO empty.
- rd_frame_start  out  1  one-cycle pulse on the vs_in rising edge; the DDR reader restarts its frame address on it.
- vs_out  out  1  vs_in delayed 2 cycles.
- hs_out  out  1  hs_in delayed 2 cycles.
- de_out  out  1  de_in delayed 2 cycles.
- r_out, g_out, b_out  out  8 each  output pixel.
- underflow  out  1  sticky flag; cleared by reset or rd_frame_start.

Behaviour:
- Reset (rst_n=0 at a clock edge): every output is 0, counters are 0, and state = S_WAIT_VS.
- Counters:
  - out_x[11:0] increments per de_in cycle and clears on the de_in falling edge.
  - out_y[11:0] increments on each de_in falling edge and saturates at 2*SRC_YRES.
  - Both clear while vs_in=1.
- State machine:
  - S_WAIT_VS: no rd_req. Go to S_FRAME on the vs_in rising edge.
  - S_FRAME: normal operation. Go to S_DONE when out_y reaches 2*SRC_YRES.
  - S_DONE: no rd_req; pixels are black. Go to S_FRAME on the vs_in rising edge.
  - A vs_in rising edge in any state: restart the frame, pulse rd_frame_start, clear underflow.
- Reset mid-frame returns to S_WAIT_VS, so no reads occur until the next vsync. This prevents FIFO misalignment.
- Even output line (out_y[0]=0), S_FRAME, de_in=1, out_x<2*SRC_XRES, out_x[0]=0:
  - If rd_empty=0: rd_req=1 combinationally.
  - If rd_empty=1: no rd_req, underflow←1, and this pixel pair is black.
- Cycle t+1 after a read:
  - Write rd_data[23:0] into the line buffer at out_x>>1.
  - Latch it into the hold register.
  - Drive the output register at t+2.
- Odd output pixel on an even line: output the hold register (same source pixel).
- Odd output line:
  - Issue a line-buffer read at address out_x>>1 at t.
  - RAM output is registered at t+1; the output register is loaded at t+2.
  - No FIFO reads.
- Total latency from de_in to pixel is fixed at 2 cycles, matching the vs/hs/de delay.
- When de_out=0, RGB is 0.
- Excess pixels (out_x≥2*SRC_XRES) or lines (S_DONE): black, no reads, de passes through delayed.
- Line-buffer write and read never address the same line simultaneously, so there is no collision handling.
- Read count per frame is exactly SRC_XRES*SRC_YRES = 518400, absent underflow.

Decomposition:
- Shared package video_pkg: SRC_XRES/SRC_YRES defaults, the RGB888 pixel struct, and the pixel-word pack/unpack constant (pad byte 8'h00).
- One sub-module, line_buf_sdp: simple dual-port RAM, 2**LB_AW×24, one write port and one read port, 1-cycle registered read. Infers block RAM.
- The FSM, counters, and output pipeline stay in the top module.

Test Plan:
- Reset then a full 1080p frame, FIFO preloaded with pixel value = source index → 518400 rd_req pulses. Output (x,y) equals source index (y>>1)*960+(x>>1). Output 1920×1080, 2-cycle latency vs de_in.
- Line 0 with source pixels 0x00112233, 0x00445566 → outputs 112233, 112233, 445566, 445566. Line 1 repeats identical values with rd_req=0 throughout.
- rd_empty forced high for 1 cycle at out_x=100 on line 4 → that pixel pair is black, underflow=1. The next frame's rd_frame_start clears it.
- rst_n low for 3 cycles mid-frame (line 300) → all outputs 0 and no rd_req until the next vs_in rise. Then rd_frame_start pulses once and the next frame is correct.
- Timing with 1100 active lines and 1930 de cycles per line → reads stop after line 1079 and after out_x=1919. Excess pixels are black with de_out still asserted.
- vs_in rising edge at line 500 → rd_frame_start pulses, out_y restarts at 0, and the first read occurs at the first de_in of the new frame.
